// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles the two requester ports, the ALU drive/return path and the
//   status outputs of the shared-ALU arbiter.
//   Modports:
//     slave  - the arbiter: samples requests/operands/alu_out, drives the
//              ALU operands, grants, done pulses, result and busy.
//     master - the surrounding logic: drives requests/operands and the ALU
//              return value, observes everything else.
//   Parameters: WIDTH (operand/result width), SEL_W (opcode width).
interface alu_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
) ();
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [SEL_W-1:0] sel0;
  logic [SEL_W-1:0] sel1;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, sel0, sel1, alu_out,
    output alu_a, alu_b, alu_sel, gnt0, gnt1, done0, done1, result, busy
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, sel0, sel1, alu_out,
    input  alu_a, alu_b, alu_sel, gnt0, gnt1, done0, done1, result, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. A winner is picked
//   in IDLE, its operands are latched and driven onto the ALU for exactly one
//   EXEC cycle, the ALU output is registered into result, and a one-cycle
//   done pulse for the owner is issued in DONE.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous, active-high reset
//     bus  - alu_arbiter_if.slave: req0/req1, a*/b*/sel* in, alu_out in,
//            alu_a/alu_b/alu_sel out, gnt0/gnt1, done0/done1, result, busy out
//   Configuration macro:
//     ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie and
//                             no round-robin history is kept. Default
//                             (undefined): round-robin arbitration.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic             owner_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  logic [SEL_W-1:0] alu_sel_reg;
  logic [WIDTH-1:0] result_reg;
  logic             gnt0_reg;
  logic             gnt1_reg;
  logic             done0_reg;
  logic             done1_reg;
  logic             busy_reg;
  logic             winner;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it asks; requester 1 only when alone.
  assign winner = ~bus.req0;
`else
  logic last_reg;
  // On a tie the requester that was not served last wins; otherwise the
  // single active requester wins.
  assign winner = (bus.req0 && bus.req1) ? ~last_reg : bus.req1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b0;
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
      alu_sel_reg <= '0;
      result_reg  <= '0;
      gnt0_reg    <= 1'b0;
      gnt1_reg    <= 1'b0;
      done0_reg   <= 1'b0;
      done1_reg   <= 1'b0;
      busy_reg    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_reg    <= 1'b1;  // so requester 0 wins the first tie
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            // The ALU drive registers double as the operand latch, so the
            // operands are frozen for the EXEC cycle.
            owner_reg   <= winner;
            alu_a_reg   <= winner ? bus.a1   : bus.a0;
            alu_b_reg   <= winner ? bus.b1   : bus.b0;
            alu_sel_reg <= winner ? bus.sel1 : bus.sel0;
            gnt0_reg    <= ~winner;
            gnt1_reg    <= winner;
            busy_reg    <= 1'b1;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          result_reg  <= bus.alu_out;
          alu_a_reg   <= '0;
          alu_b_reg   <= '0;
          alu_sel_reg <= '0;
          done0_reg   <= ~owner_reg;
          done1_reg   <= owner_reg;
          state_reg   <= DONE;
        end
        DONE: begin
          // Requests are ignored here; a request still high next cycle is new.
          done0_reg <= 1'b0;
          done1_reg <= 1'b0;
          gnt0_reg  <= 1'b0;
          gnt1_reg  <= 1'b0;
          busy_reg  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_reg  <= owner_reg;
`endif
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a   = alu_a_reg;
  assign bus.alu_b   = alu_b_reg;
  assign bus.alu_sel = alu_sel_reg;
  assign bus.result  = result_reg;
  assign bus.gnt0    = gnt0_reg;
  assign bus.gnt1    = gnt1_reg;
  assign bus.done0   = done0_reg;
  assign bus.done1   = done1_reg;
  assign bus.busy    = busy_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter with a behavioural ALU (A+B mod 16 for
//   every opcode). Expected {owner, result} pairs are queued when a request
//   is issued and popped when a done pulse appears.
module tb_alu_arbiter;
  localparam int WIDTH = 4;
  localparam int SEL_W = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    logic             owner;
    logic [WIDTH-1:0] res;
  } exp_t;

  exp_t sb_q[$];

  alu_arbiter_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural ALU: sum truncated to WIDTH bits regardless of opcode.
  assign bus.alu_out = bus.alu_a + bus.alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic owner, input logic [WIDTH-1:0] res);
    exp_t e;
    e.owner = owner;
    e.res   = res;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (bus.done0 || bus.done1)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {6'b0, bus.done1, bus.done0}, 8'h00);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_done0", {7'b0, bus.done0}, {7'b0, ~e.owner});
        check("sb_done1", {7'b0, bus.done1}, {7'b0, e.owner});
        check("sb_result", {4'b0, bus.result}, {4'b0, e.res});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;
    bus.sel0 = '0;
    bus.sel1 = '0;

    // ---- reset with random inputs
    for (int i = 0; i < 2; i++) begin
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      bus.a0   = 4'($urandom);
      bus.b0   = 4'($urandom);
      bus.a1   = 4'($urandom);
      bus.b1   = 4'($urandom);
      bus.sel0 = 3'($urandom);
      bus.sel1 = 3'($urandom);
      tick();
    end
    check("rst_alu_a", {4'b0, bus.alu_a}, 8'h00);
    check("rst_alu_b", {4'b0, bus.alu_b}, 8'h00);
    check("rst_alu_sel", {5'b0, bus.alu_sel}, 8'h00);
    check("rst_gnt", {6'b0, bus.gnt1, bus.gnt0}, 8'h00);
    check("rst_done", {6'b0, bus.done1, bus.done0}, 8'h00);
    check("rst_result", {4'b0, bus.result}, 8'h00);
    check("rst_busy", {7'b0, bus.busy}, 8'h00);
    rst      = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();

    // ---- single request from requester 0
    bus.req0 = 1'b1; bus.a0 = 4'd3; bus.b0 = 4'd1; bus.sel0 = 3'b000;
    push(1'b0, 4'd4);
    tick();  // t+1 EXEC
    check("single_gnt0", {7'b0, bus.gnt0}, 8'h01);
    check("single_gnt1", {7'b0, bus.gnt1}, 8'h00);
    check("single_alu_a", {4'b0, bus.alu_a}, 8'h03);
    check("single_alu_b", {4'b0, bus.alu_b}, 8'h01);
    check("single_alu_sel", {5'b0, bus.alu_sel}, 8'h00);
    check("single_busy", {7'b0, bus.busy}, 8'h01);
    tick();  // t+2 DONE
    check("single_done0", {7'b0, bus.done0}, 8'h01);
    check("single_done1", {7'b0, bus.done1}, 8'h00);
    check("single_result", {4'b0, bus.result}, 8'h04);
    check("single_alu_a_done", {4'b0, bus.alu_a}, 8'h00);
    bus.req0 = 1'b0;
    tick();  // t+3 IDLE
    check("single_idle_busy", {7'b0, bus.busy}, 8'h00);
    check("single_idle_done0", {7'b0, bus.done0}, 8'h00);

    // ---- operands changed after grant
    bus.req1 = 1'b1; bus.a1 = 4'd12; bus.b1 = 4'd10; bus.sel1 = 3'b010;
    push(1'b1, 4'd6);
    tick();  // EXEC
    check("late_gnt1", {7'b0, bus.gnt1}, 8'h01);
    check("late_alu_a", {4'b0, bus.alu_a}, 8'h0c);
    check("late_alu_sel", {5'b0, bus.alu_sel}, 8'h02);
    bus.a1 = 4'd0;
    tick();  // DONE
    check("late_done1", {7'b0, bus.done1}, 8'h01);
    check("late_result", {4'b0, bus.result}, 8'h06);
    bus.req1 = 1'b0;
    tick();

    // ---- simultaneous requests after reset
    rst = 1'b1;
    tick();
    tick();
    check("rst2_result", {4'b0, bus.result}, 8'h00);
    rst = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 4'd1; bus.b0 = 4'd1; bus.sel0 = 3'b001;
    bus.req1 = 1'b1; bus.a1 = 4'd2; bus.b1 = 4'd2; bus.sel1 = 3'b011;
`ifdef ALU_ARB_FIXED_PRIO_EN
    push(1'b0, 4'd2); push(1'b0, 4'd2); push(1'b0, 4'd2);
`else
    push(1'b0, 4'd2); push(1'b1, 4'd4); push(1'b0, 4'd2);
`endif
    tick(); tick();  // t+2: first DONE
    check("tie1_done0", {7'b0, bus.done0}, 8'h01);
    tick(); tick(); tick();  // t+5: second DONE
`ifdef ALU_ARB_FIXED_PRIO_EN
    check("tie2_done0", {7'b0, bus.done0}, 8'h01);
    check("tie2_result", {4'b0, bus.result}, 8'h02);
`else
    check("tie2_done1", {7'b0, bus.done1}, 8'h01);
    check("tie2_result", {4'b0, bus.result}, 8'h04);
`endif
    tick(); tick(); tick();  // t+8: third DONE
    check("tie3_done0", {7'b0, bus.done0}, 8'h01);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    check("tie_idle_busy", {7'b0, bus.busy}, 8'h00);

    // ---- reset during EXEC
    bus.req0 = 1'b1; bus.a0 = 4'd5; bus.b0 = 4'd6; bus.sel0 = 3'b100;
    tick();  // EXEC
    check("mid_gnt0", {7'b0, bus.gnt0}, 8'h01);
    rst      = 1'b1;
    bus.req0 = 1'b0;
    tick();
    check("mid_busy", {7'b0, bus.busy}, 8'h00);
    check("mid_done0", {7'b0, bus.done0}, 8'h00);
    check("mid_result", {4'b0, bus.result}, 8'h00);
    check("mid_gnt0_clr", {7'b0, bus.gnt0}, 8'h00);
    rst = 1'b0;
    tick();
    check("mid_after_busy", {7'b0, bus.busy}, 8'h00);
    check("mid_after_done", {6'b0, bus.done1, bus.done0}, 8'h00);

    // ---- back-to-back from requester 0 with wrap-around
    bus.req0 = 1'b1; bus.a0 = 4'd3; bus.b0 = 4'd4; bus.sel0 = 3'b000;
    push(1'b0, 4'd7);
    tick(); tick();  // DONE
    check("b2b_done0_a", {7'b0, bus.done0}, 8'h01);
    check("b2b_result_a", {4'b0, bus.result}, 8'h07);
    bus.req0 = 1'b0;
    tick();  // IDLE after done
    check("b2b_idle_busy", {7'b0, bus.busy}, 8'h00);
    bus.req0 = 1'b1; bus.a0 = 4'd8; bus.b0 = 4'd8;
    push(1'b0, 4'd0);
    tick();  // EXEC, two cycles after previous done
    check("b2b_gnt0", {7'b0, bus.gnt0}, 8'h01);
    check("b2b_alu_a", {4'b0, bus.alu_a}, 8'h08);
    tick();  // DONE
    check("b2b_done0_b", {7'b0, bus.done0}, 8'h01);
    check("b2b_result_b", {4'b0, bus.result}, 8'h00);
    bus.req0 = 1'b0;
    tick();

    // ---- drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("sb_drained", 8'(sb_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 4-bit `ALU` instance between two requesters. Each requester presents operands and an opcode with a level request. The arbiter selects a winner, latches its operands, and drives them onto the ALU for one cycle. It captures `ALU_Out` and returns the result with a one-cycle done pulse. It sits between the requesting control units and the combinational `ALU`, which remains unmodified.

## Interface
- `WIDTH`, default 4: operand and result width; must match the `ALU` datapath.
- `SEL_W`, default 3: opcode width; must match the `ALU` `Sel` port.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  level request from requester 0 / 1.
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands per requester; sampled only when that request is granted.
- `sel0`, `sel1`  in  SEL_W  opcode per requester; sampled with the operands.
- `alu_a`, `alu_b`  out  WIDTH  to `ALU` `A`/`B`.
- `alu_sel`  out  SEL_W  to `ALU` `Sel`.
- `alu_out`  in  WIDTH  from `ALU` `ALU_Out`; combinational from `alu_a`/`alu_b`/`alu_sel`.
- `gnt0`, `gnt1`  out  1  high while that requester's transaction is in EXEC or DONE.
- `done0`, `done1`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  WIDTH  registered ALU result of the last completed transaction.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, DONE. The reset state is IDLE.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - Otherwise pick a winner, latch its `a`/`b`/`sel` into operand registers, record `owner`, and go to EXEC.
- EXEC:
  - Drive the operand registers onto `alu_a`/`alu_b`/`alu_sel`.
  - Register `alu_out` into `result` at the end of the cycle.
  - Go to DONE.
- DONE:
  - Assert `done[owner]` and update `last` to `owner`.
  - Go to IDLE.
  - Requests are not sampled in this cycle.
- Arbitration:
  - If exactly one request is asserted, that requester wins.
  - If both are asserted, the requester that is not `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- Requester rule: drop `req` on the clock edge that samples `done=1`. A `req` still high in the following IDLE cycle is a new request.
- `alu_a`, `alu_b` and `alu_sel` are held at 0 in IDLE and DONE. They carry live values only in EXEC.
- Operands change after grant and have no effect on the transaction in flight.
- Reset mid-transaction:
  - Returns to IDLE and discards the operation.
  - No `done` pulse is produced.
  - `result` clears to 0.
- Reset values:
  - `alu_a`, `alu_b`, `alu_sel`: 0.
  - `gnt0`, `gnt1`, `done0`, `done1`: 0.
  - `result`: 0.
  - `busy`: 0.
- Arithmetic is entirely inside the `ALU`. The arbiter neither widens nor truncates data; `result` is exactly `alu_out` sampled in EXEC.

## Timing
- Transaction timeline, with request first sampled in IDLE at cycle t:
  - Cycle t+1: EXEC; `gnt` is high and the ALU is driven.
  - Cycle t+2: DONE; `done` pulses and `result` is valid.
  - Cycle t+3: IDLE again.
- Latency from `req` sampled to `done` is 2 cycles.
- Throughput is at most one operation per 3 cycles.
- With both requesters continuously re-requesting, grants strictly alternate. Worst-case wait for a requester is 3 cycles.
- `result` holds its value until the next EXEC cycle completes.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. `req0` always wins a tie. `last` is not implemented, and requester 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
The bench uses a behavioural ALU model: `alu_out = alu_a + alu_b` mod 16, for every `sel`.
- Reset: hold `rst` for 2 cycles with random inputs -> every output is 0 and `busy=0`.
- Single request: `req0=1`, `a0=3`, `b0=1`, `sel0=000` at t -> `gnt0=1` and `alu_a=3`, `alu_b=1`, `alu_sel=000` at t+1; `done0=1` and `result=4` at t+2; `done1` never pulses.
- Operands changed after grant: `req1` with `a1=12`, `b1=10`, `sel1=010`; change `a1` to 0 in EXEC -> `result=6`, from 12+10 mod 16.
- Simultaneous requests after reset: both asserted with `a0=1`, `b0=1` and `a1=2`, `b1=2`, both held -> order is `done0` with `result=2`, then `done1` with `result=4`, then `done0` again. Repeat with `ALU_ARB_FIXED_PRIO_EN` defined -> only `done0` pulses while `req0` stays high.
- Reset mid-operation: assert `rst` during EXEC -> no `done` pulse, `result=0`, next cycle IDLE.
- Back-to-back from one requester: `req0` re-asserted in the cycle after `done0` with `a0=8`, `b0=8` -> new EXEC 2 cycles after the previous `done0`, `result=0` (wrap-around).
